user_def_min_max_reduce_ctrl: RTL and testbench

Sequencer that drives the packed-int8 min/max custom-instruction accelerator as a bus master.
- Configures the signed/unsigned mode, then streams cfg_len 32-bit words from a valid/ready source through the accelerator.
- Keeps a running lane-wise accumulator. Optionally folds the 4 lanes into one scalar.
- Frees the CPU from issuing one custom instruction per word during TinyML pooling/argmax steps.

---
 rtl/user_def_min_max_reduce_ctrl_pkg.sv | 35 +++
 rtl/user_def_min_max_reduce_ctrl.sv | 170 +++++++++++++++++
 tb/tb_user_def_min_max_reduce_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_def_min_max_reduce_ctrl_pkg.sv
// Shared constants for the packed-int8 min/max reduction sequencer:
// accelerator function ids, FSM state encoding and per-mode identity words.
package user_def_min_max_reduce_ctrl_pkg;

  localparam int FID_W = 10;

  localparam logic [FID_W-1:0] FID_CFG = 10'd0;
  localparam logic [FID_W-1:0] FID_MAX = 10'd1;
  localparam logic [FID_W-1:0] FID_MIN = 10'd2;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    CFG_WAIT,
    LOAD,
    FETCH,
    ISSUE,
    WAIT,
    H16,
    H8,
    DONE
  } state_e;

  // Neutral element of each reduction, replicated over the four lanes.
  localparam logic [31:0] ID_UMAX = 32'h0000_0000;
  localparam logic [31:0] ID_UMIN = 32'hFFFF_FFFF;
  localparam logic [31:0] ID_SMAX = 32'h8080_8080;
  localparam logic [31:0] ID_SMIN = 32'h7F7F_7F7F;

  function automatic logic [31:0] identity(input logic is_signed, input logic is_min);
    if (is_signed) return is_min ? ID_SMIN : ID_SMAX;
    else           return is_min ? ID_UMIN : ID_UMAX;
  endfunction

endpackage

// File: rtl/user_def_min_max_reduce_ctrl.sv
// Bus-master sequencer: configures the int8 min/max accelerator, streams
// cfg_len source words through it and optionally folds the lanes to a scalar.
module user_def_min_max_reduce_ctrl
  import user_def_min_max_reduce_ctrl_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter bit HREDUCE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cfg_signed,
  input  logic              cfg_op,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [31:0]       src_data,
  output logic              acc_cmd_valid,
  input  logic              acc_cmd_ready,
  output logic [FID_W-1:0]  acc_cmd_function_id,
  output logic [31:0]       acc_cmd_inputs_0,
  output logic [31:0]       acc_cmd_inputs_1,
  input  logic              acc_rsp_valid,
  output logic              acc_rsp_ready,
  input  logic [31:0]       acc_rsp_outputs_0
);

  state_e             state, state_nxt;
  logic               cfg_signed_q, cfg_op_q;
  logic [LEN_W-1:0]   len_q, cnt_q, cnt_inc;
  logic [31:0]        acc_q, word_q, result_q;
  logic               h_sent_q;   // horizontal-pass command accepted, awaiting its response
  logic [FID_W-1:0]   op_fid;

  assign op_fid        = cfg_op_q ? FID_MIN : FID_MAX;
  assign cnt_inc       = cnt_q + LEN_W'(1);
  assign busy          = (state != IDLE) && (state != DONE);
  // The accelerator gates its own handshakes with this, so it must cover the whole job.
  assign acc_rsp_ready = busy;
  assign result        = result_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt           = state;
    done                = 1'b0;
    src_ready           = 1'b0;
    acc_cmd_valid       = 1'b0;
    acc_cmd_function_id = '0;
    acc_cmd_inputs_0    = '0;
    acc_cmd_inputs_1    = '0;

    unique case (state)
      IDLE: if (start) state_nxt = (cfg_len == '0) ? DONE : CFG;
      CFG: begin
        acc_cmd_valid       = 1'b1;
        acc_cmd_function_id = FID_CFG;
        acc_cmd_inputs_0    = {31'b0, cfg_signed_q};
        if (acc_cmd_ready) state_nxt = CFG_WAIT;
      end
      CFG_WAIT: if (acc_rsp_valid) state_nxt = LOAD;
      LOAD: begin
        src_ready = 1'b1;
        if (src_valid) begin
          if (len_q != LEN_W'(1)) state_nxt = FETCH;
          else                    state_nxt = HREDUCE ? H16 : DONE;
        end
      end
      FETCH: begin
        src_ready = 1'b1;
        if (src_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        acc_cmd_valid       = 1'b1;
        acc_cmd_function_id = op_fid;
        acc_cmd_inputs_0    = word_q;
        acc_cmd_inputs_1    = acc_q;
        if (acc_cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (acc_rsp_valid) begin
          if (cnt_inc != len_q) state_nxt = FETCH;
          else                  state_nxt = HREDUCE ? H16 : DONE;
        end
      end
      H16: begin
        if (!h_sent_q) begin
          acc_cmd_valid       = 1'b1;
          acc_cmd_function_id = op_fid;
          acc_cmd_inputs_0    = acc_q;
          acc_cmd_inputs_1    = {acc_q[15:0], acc_q[31:16]};
        end
        if (h_sent_q && acc_rsp_valid) state_nxt = H8;
      end
      H8: begin
        if (!h_sent_q) begin
          acc_cmd_valid       = 1'b1;
          acc_cmd_function_id = op_fid;
          acc_cmd_inputs_0    = acc_q;
          acc_cmd_inputs_1    = {acc_q[7:0], acc_q[31:8]};
        end
        if (h_sent_q && acc_rsp_valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; written only on the handshake of the state that owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      cfg_signed_q <= 1'b0;
      cfg_op_q     <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      result_q     <= '0;
      h_sent_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cfg_signed_q <= cfg_signed;
            cfg_op_q     <= cfg_op;
            len_q        <= cfg_len;
            cnt_q        <= '0;
            h_sent_q     <= 1'b0;
            if (cfg_len == '0) acc_q <= identity(cfg_signed, cfg_op);
          end
        end
        LOAD: begin
          if (src_valid) begin
            acc_q <= src_data;
            cnt_q <= LEN_W'(1);
          end
        end
        FETCH: if (src_valid) word_q <= src_data;
        WAIT: begin
          if (acc_rsp_valid) begin
            acc_q <= acc_rsp_outputs_0;
            cnt_q <= cnt_inc;
          end
        end
        H16, H8: begin
          if (!h_sent_q && acc_cmd_ready) begin
            h_sent_q <= 1'b1;
          end else if (h_sent_q && acc_rsp_valid) begin
            acc_q    <= acc_rsp_outputs_0;
            h_sent_q <= 1'b0;
          end
        end
        DONE: result_q <= acc_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_def_min_max_reduce_ctrl.sv
// Self-checking bench: two instances (HREDUCE 0 and 1) against a behavioural
// accelerator/source model and a lane-wise min/max reference.
module tb_user_def_min_max_reduce_ctrl;
  import user_def_min_max_reduce_ctrl_pkg::*;

  localparam int LEN_W = 16;
  localparam int NW    = 8;
  localparam int NLOG  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_s [2];
  logic              cfg_signed_s [2];
  logic              cfg_op_s [2];
  logic [LEN_W-1:0]  cfg_len_s [2];
  logic              busy_s [2];
  logic              done_s [2];
  logic [31:0]       result_s [2];
  logic              src_valid_s [2];
  logic              src_ready_s [2];
  logic [31:0]       src_data_s [2];
  logic              cmd_valid_s [2];
  logic              cmd_ready_s [2];
  logic [FID_W-1:0]  cmd_fid_s [2];
  logic [31:0]       cmd_in0_s [2];
  logic [31:0]       cmd_in1_s [2];
  logic              rsp_valid_s [2];
  logic              rsp_ready_s [2];
  logic [31:0]       rsp_data_s [2];

  user_def_min_max_reduce_ctrl #(.LEN_W(LEN_W), .HREDUCE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .cfg_signed(cfg_signed_s[0]),
    .cfg_op(cfg_op_s[0]), .cfg_len(cfg_len_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .result(result_s[0]), .src_valid(src_valid_s[0]), .src_ready(src_ready_s[0]),
    .src_data(src_data_s[0]), .acc_cmd_valid(cmd_valid_s[0]), .acc_cmd_ready(cmd_ready_s[0]),
    .acc_cmd_function_id(cmd_fid_s[0]), .acc_cmd_inputs_0(cmd_in0_s[0]),
    .acc_cmd_inputs_1(cmd_in1_s[0]), .acc_rsp_valid(rsp_valid_s[0]),
    .acc_rsp_ready(rsp_ready_s[0]), .acc_rsp_outputs_0(rsp_data_s[0]));

  user_def_min_max_reduce_ctrl #(.LEN_W(LEN_W), .HREDUCE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .cfg_signed(cfg_signed_s[1]),
    .cfg_op(cfg_op_s[1]), .cfg_len(cfg_len_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .result(result_s[1]), .src_valid(src_valid_s[1]), .src_ready(src_ready_s[1]),
    .src_data(src_data_s[1]), .acc_cmd_valid(cmd_valid_s[1]), .acc_cmd_ready(cmd_ready_s[1]),
    .acc_cmd_function_id(cmd_fid_s[1]), .acc_cmd_inputs_0(cmd_in0_s[1]),
    .acc_cmd_inputs_1(cmd_in1_s[1]), .acc_rsp_valid(rsp_valid_s[1]),
    .acc_rsp_ready(rsp_ready_s[1]), .acc_rsp_outputs_0(rsp_data_s[1]));

  int tests = 0;
  int failed = 0;

  // Source and accelerator model state, one slot per instance.
  logic [31:0]      src_words [2][NW];
  int               src_n [2], src_rd [2], src_gap [2], gap_after_first [2];
  bit               src_ready_seen [2], cmd_valid_seen [2];
  int               cmd_cnt [2], stall_req [2], stall_seen [2];
  logic [FID_W-1:0] fid_log [2][NLOG];
  logic [31:0]      in0_log [2][NLOG];
  bit               acc_signed [2], rsp_pend [2];
  int               rsp_dly [2];
  logic [31:0]      rsp_val [2];
  bit               stl [2];
  logic [FID_W-1:0] snap_fid [2];
  logic [31:0]      snap_in0 [2], snap_in1 [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What the accelerator does to one pair of packed words.
  function automatic logic [31:0] acc_op(input logic [31:0] a, input logic [31:0] b,
                                         input bit sgn, input bit mn);
    logic [31:0] r;
    logic [7:0] x, y;
    bit lt;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      x  = a[8*l +: 8];
      y  = b[8*l +: 8];
      lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
      r[8*l +: 8] = (mn ? lt : !lt) ? x : y;
    end
    return r;
  endfunction

  // Reference: per-lane extremum over all words as integers, optional scalar fold.
  function automatic logic [31:0] ref_result(input int g, input bit sgn, input bit mn, input int len);
    int best [4];
    int v, s;
    logic [7:0] b;
    logic [31:0] r;
    for (int l = 0; l < 4; l++) best[l] = sgn ? (mn ? 127 : -128) : (mn ? 255 : 0);
    for (int i = 0; i < len; i++)
      for (int l = 0; l < 4; l++) begin
        b = src_words[g][i][8*l +: 8];
        v = sgn ? int'($signed(b)) : int'(b);
        best[l] = mn ? ((v < best[l]) ? v : best[l]) : ((v > best[l]) ? v : best[l]);
      end
    if (g == 1 && len > 0) begin
      s = best[0];
      for (int l = 1; l < 4; l++) s = mn ? ((best[l] < s) ? best[l] : s) : ((best[l] > s) ? best[l] : s);
      for (int l = 0; l < 4; l++) best[l] = s;
    end
    r = '0;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'(best[l]);
    return r;
  endfunction

  task automatic model_step(input int g);
    if (!reset_n) begin
      rsp_pend[g] = 1'b0; rsp_valid_s[g] = 1'b0; cmd_ready_s[g] = 1'b0;
      src_valid_s[g] = 1'b0; stl[g] = 1'b0;
      return;
    end
    if (src_ready_s[g]) src_ready_seen[g] = 1'b1;
    if (cmd_valid_s[g]) cmd_valid_seen[g] = 1'b1;
    if (stl[g]) begin
      check("cmd_hold_valid", 32'(cmd_valid_s[g]), 32'd1);
      check("cmd_hold_fid", 32'(cmd_fid_s[g]), 32'(snap_fid[g]));
      check("cmd_hold_in0", cmd_in0_s[g], snap_in0[g]);
      check("cmd_hold_in1", cmd_in1_s[g], snap_in1[g]);
    end
    rsp_valid_s[g] = 1'b0;
    if (rsp_pend[g]) begin
      if (rsp_dly[g] > 0) rsp_dly[g]--;
      else begin
        rsp_valid_s[g] = 1'b1;
        rsp_data_s[g]  = rsp_val[g];
        if (rsp_ready_s[g]) rsp_pend[g] = 1'b0;
      end
    end
    if (cmd_valid_s[g] && cmd_fid_s[g] != FID_CFG && stall_req[g] > 0) begin
      cmd_ready_s[g] = 1'b0;
      stall_req[g]--;
      stall_seen[g]++;
    end else cmd_ready_s[g] = 1'b1;
    stl[g] = cmd_valid_s[g] && !cmd_ready_s[g];
    snap_fid[g] = cmd_fid_s[g]; snap_in0[g] = cmd_in0_s[g]; snap_in1[g] = cmd_in1_s[g];
    if (cmd_valid_s[g] && cmd_ready_s[g]) begin
      if (cmd_cnt[g] < NLOG) begin
        fid_log[g][cmd_cnt[g]] = cmd_fid_s[g];
        in0_log[g][cmd_cnt[g]] = cmd_in0_s[g];
      end
      cmd_cnt[g]++;
      if (cmd_fid_s[g] == FID_CFG) begin
        acc_signed[g] = cmd_in0_s[g][0];
        rsp_val[g]    = $urandom;
      end else begin
        rsp_val[g] = acc_op(cmd_in0_s[g], cmd_in1_s[g], acc_signed[g], cmd_fid_s[g] == FID_MIN);
      end
      rsp_pend[g] = 1'b1;
      rsp_dly[g]  = $urandom_range(0, 2);
    end
    src_valid_s[g] = 1'b0;
    src_data_s[g]  = '0;
    if (src_gap[g] > 0) src_gap[g]--;
    else if (src_rd[g] < src_n[g]) begin
      src_valid_s[g] = 1'b1;
      src_data_s[g]  = src_words[g][src_rd[g]];
      if (src_ready_s[g]) begin
        src_rd[g]++;
        if (src_rd[g] == 1) src_gap[g] = gap_after_first[g];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) model_step(g);
  endtask

  task automatic prep_job(input int g, input bit sgn, input bit mn, input int len,
                          input int extra, input int gap, input int stall);
    src_n[g] = len + extra; src_rd[g] = 0; src_gap[g] = 0; gap_after_first[g] = gap;
    stall_req[g] = stall; stall_seen[g] = 0; cmd_cnt[g] = 0;
    src_ready_seen[g] = 1'b0; cmd_valid_seen[g] = 1'b0;
    cfg_signed_s[g] = sgn; cfg_op_s[g] = mn; cfg_len_s[g] = LEN_W'(len);
    start_s[g] = 1'b1;
    tick();
    start_s[g] = 1'b0;
  endtask

  task automatic run_job(input int g, input bit sgn, input bit mn, input int len,
                         input int extra, input int gap, input int stall,
                         output logic [31:0] res, output int ncmd, output int lat);
    prep_job(g, sgn, mn, len, extra, gap, stall);
    if (len > 0) check("busy_after_start", 32'(busy_s[g]), 32'd1);
    lat = 0;
    while (!done_s[g] && lat < 3000) begin tick(); lat++; end
    check("done_seen", 32'(done_s[g]), 32'd1);
    check("busy_low_at_done", 32'(busy_s[g]), 32'd0);
    tick();
    check("done_single_pulse", 32'(done_s[g]), 32'd0);
    res  = result_s[g];
    ncmd = cmd_cnt[g];
    check("words_consumed", 32'(src_rd[g]), 32'(len));
  endtask

  typedef struct packed {
    logic        g;
    logic        sgn;
    logic        mn;
    logic [3:0]  len;
    logic [31:0] w0, w1, w2;
    logic [31:0] exp;
    logic [3:0]  cmds;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic sgn, input logic mn, input logic [3:0] len,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] exp, input logic [3:0] cmds);
    vec_t v;
    v.g = g; v.sgn = sgn; v.mn = mn; v.len = len;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.exp = exp; v.cmds = cmds;
    return v;
  endfunction

  localparam logic [31:0] WA = 32'h01FF_7F80;
  localparam logic [31:0] WB = 32'h1020_0304;
  localparam logic [31:0] WC = 32'h8001_8081;

  vec_t        vecs [7];
  logic [31:0] res, exp_r;
  int          ncmd, lat, rg, rlen, rextra;
  bit          rsgn, rmn;
  logic [FID_W-1:0] efid;

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 0; cfg_signed_s[g] = 0; cfg_op_s[g] = 0; cfg_len_s[g] = '0;
      src_valid_s[g] = 0; src_data_s[g] = '0; cmd_ready_s[g] = 0;
      rsp_valid_s[g] = 0; rsp_data_s[g] = '0; src_n[g] = 0; src_rd[g] = 0;
      src_gap[g] = 0; stall_req[g] = 0; cmd_cnt[g] = 0; rsp_pend[g] = 0; stl[g] = 0;
      acc_signed[g] = 0; rsp_dly[g] = 0; rsp_val[g] = '0; stall_seen[g] = 0;
    end

    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_busy", 32'(busy_s[g]), 32'd0);
      check("rst_done", 32'(done_s[g]), 32'd0);
      check("rst_result", result_s[g], 32'd0);
      check("rst_src_ready", 32'(src_ready_s[g]), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid_s[g]), 32'd0);
      check("rst_cmd_fid", 32'(cmd_fid_s[g]), 32'd0);
      check("rst_cmd_in0", cmd_in0_s[g], 32'd0);
      check("rst_cmd_in1", cmd_in1_s[g], 32'd0);
      check("rst_rsp_ready", 32'(rsp_ready_s[g]), 32'd0);
    end
    reset_n = 1'b1;
    tick();

    vecs[0] = mk(0, 0, 0, 3, WA, WB, WC, 32'h80FF_8081, 3);
    vecs[1] = mk(0, 1, 1, 3, WA, WB, WC, 32'h80FF_8080, 3);
    vecs[2] = mk(1, 0, 0, 1, 32'h1234_5678, 0, 0, 32'h7878_7878, 3);
    vecs[3] = mk(1, 1, 1, 0, 0, 0, 0, 32'h7F7F_7F7F, 0);
    vecs[4] = mk(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    vecs[5] = mk(1, 1, 0, 3, WA, WB, WC, 32'h7F7F_7F7F, 5);
    vecs[6] = mk(1, 0, 1, 2, WA, WB, 0, 32'h0101_0101, 4);

    for (int i = 0; i < 7; i++) begin
      src_words[vecs[i].g][0] = vecs[i].w0;
      src_words[vecs[i].g][1] = vecs[i].w1;
      src_words[vecs[i].g][2] = vecs[i].w2;
      run_job(int'(vecs[i].g), vecs[i].sgn, vecs[i].mn, int'(vecs[i].len), 0, 0, 0, res, ncmd, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_cmds", i), 32'(ncmd), 32'(vecs[i].cmds));
      efid = vecs[i].mn ? FID_MIN : FID_MAX;
      for (int j = 0; j < ncmd && j < NLOG; j++)
        check($sformatf("vec%0d_fid%0d", i, j), 32'(fid_log[vecs[i].g][j]),
              (j == 0) ? 32'(FID_CFG) : 32'(efid));
      if (vecs[i].len == 0) begin
        check($sformatf("vec%0d_len0_latency", i), 32'(lat <= 1), 32'd1);
        check($sformatf("vec%0d_len0_no_src", i), 32'(src_ready_seen[vecs[i].g]), 32'd0);
        check($sformatf("vec%0d_len0_no_cmd", i), 32'(cmd_valid_seen[vecs[i].g]), 32'd0);
      end
    end

    // Backpressure with a spare source beat that must stay unaccepted.
    src_words[0][0] = WA; src_words[0][1] = WB; src_words[0][2] = WC; src_words[0][3] = 32'hDEAD_BEEF;
    run_job(0, 0, 0, 3, 1, 2, 3, res, ncmd, lat);
    check("bp0_result", res, 32'h80FF_8081);
    check("bp0_cmds", 32'(ncmd), 32'd3);
    check("bp0_stalls", 32'(stall_seen[0]), 32'd3);

    src_words[1][0] = 32'h1234_5678;
    run_job(1, 0, 0, 1, 0, 0, 3, res, ncmd, lat);
    check("bp1_result", res, 32'h7878_7878);
    check("bp1_h16_rsp", in0_log[1][2], 32'h5678_5678);
    check("bp1_stalls", 32'(stall_seen[1]), 32'd3);

    // Reset while waiting for the first data response.
    src_words[0][0] = WA; src_words[0][1] = WB; src_words[0][2] = WC;
    prep_job(0, 0, 0, 3, 0, 0, 0);
    lat = 0;
    while (cmd_cnt[0] < 2 && lat < 200) begin tick(); lat++; end
    check("rst_mid_reach_wait", 32'(cmd_cnt[0] >= 2), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_s[0]), 32'd0);
    check("rst_mid_done", 32'(done_s[0]), 32'd0);
    check("rst_mid_src_ready", 32'(src_ready_s[0]), 32'd0);
    check("rst_mid_cmd_valid", 32'(cmd_valid_s[0]), 32'd0);
    check("rst_mid_rsp_ready", 32'(rsp_ready_s[0]), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_no_resume", 32'(busy_s[0]), 32'd0);
    run_job(0, 0, 0, 3, 0, 0, 0, res, ncmd, lat);
    check("rst_rerun_result", res, 32'h80FF_8081);
    check("rst_rerun_cmds", 32'(ncmd), 32'd3);

    // Randomized jobs against the reference.
    for (int t = 0; t < 40; t++) begin
      rg     = $urandom_range(0, 1);
      rsgn   = 1'($urandom_range(0, 1));
      rmn    = 1'($urandom_range(0, 1));
      rlen   = $urandom_range(0, 6);
      rextra = $urandom_range(0, 1);
      for (int k = 0; k < rlen + rextra; k++) src_words[rg][k] = $urandom;
      exp_r = ref_result(rg, rsgn, rmn, rlen);
      run_job(rg, rsgn, rmn, rlen, rextra, $urandom_range(0, 2), $urandom_range(0, 3), res, ncmd, lat);
      check($sformatf("rnd%0d_result", t), res, exp_r);
      check($sformatf("rnd%0d_cmds", t), 32'(ncmd), (rlen == 0) ? 32'd0 : 32'(rlen + 2 * rg));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
